// File: rtl/mest_pro_pkg.sv
// rtl/mest_pro_pkg.sv - shared sizes, NOP word and imem state type for mest_pro
package mest_pro_pkg;
    localparam int OP_CODE_SIZE     = 4;
    localparam int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8;
    localparam int ROM_DEPTH        = 256;

    localparam logic [INSTRUCTION_SIZE-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } imem_state_t;
endpackage

// File: rtl/mest_pro_ram_1r1w.sv
// rtl/mest_pro_ram_1r1w.sv - 1-read/1-write synchronous RAM with registered read data
module mest_pro_ram_1r1w #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Read data only updates on a read, so it holds between fetches.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/mest_pro_imem.sv
// rtl/mest_pro_imem.sv - loadable instruction memory serving mest_pro core fetches
module mest_pro_imem
    import mest_pro_pkg::*;
#(
    parameter int OP_CODE_SIZE_P     = OP_CODE_SIZE,
    parameter int INSTRUCTION_SIZE_P = OP_CODE_SIZE_P + 8 + 8 + 8,
    parameter int ROM_DEPTH_P        = ROM_DEPTH,
    localparam int ADDR_W            = $clog2(ROM_DEPTH_P)
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_load_start,
    input  logic                          i_load_valid,
    input  logic                          i_load_last,
    input  logic [INSTRUCTION_SIZE_P-1:0] i_load_data,
    output logic                          o_load_ready,
    output logic                          o_load_done,
    output logic [ADDR_W:0]               o_prog_len,
    output logic                          o_prog_loaded,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_prog_counter,
    output logic [INSTRUCTION_SIZE_P-1:0] o_instruction,
    output logic                          o_instr_valid,
    output logic                          o_fetch_err
);
    imem_state_t                   state_q, state_d;
    logic [ADDR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]               prog_len_q, prog_len_d;
    logic                          load_done_q, load_done_d;
    logic                          instr_valid_q, instr_valid_d;
    logic                          fetch_err_q, fetch_err_d;
    logic                          oob_q, oob_d;
    logic [INSTRUCTION_SIZE_P-1:0] instr_hold_q, instr_hold_d;

    logic                          ram_we;
    logic                          ram_re;
    logic [INSTRUCTION_SIZE_P-1:0] ram_rdata;

    mest_pro_ram_1r1w #(
        .DEPTH (ROM_DEPTH_P),
        .WIDTH (INSTRUCTION_SIZE_P)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (i_load_data),
        .rd_en   (ram_re),
        .rd_addr (i_prog_counter),
        .rd_data (ram_rdata)
    );

    // Out-of-range fetches return NOP; rejected fetches keep the last word.
    assign o_instruction = instr_valid_q ? (oob_q ? INSTRUCTION_SIZE_P'(NOP) : ram_rdata)
                                         : instr_hold_q;
    assign o_instr_valid = instr_valid_q;
    assign o_fetch_err   = fetch_err_q;
    assign o_load_ready  = (state_q == LOAD);
    assign o_load_done   = load_done_q;
    assign o_prog_len    = prog_len_q;
    assign o_prog_loaded = (state_q == READY);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        prog_len_d    = prog_len_q;
        load_done_d   = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        oob_d         = 1'b0;
        instr_hold_d  = o_instruction;

        if (i_req) begin
            if (state_q == READY) begin
                instr_valid_d = 1'b1;
                if ({1'b0, i_prog_counter} < prog_len_q) begin
                    ram_re = 1'b1;
                end else begin
                    oob_d       = 1'b1;
                    fetch_err_d = 1'b1;
                end
            end else begin
                fetch_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, READY: begin
                if (i_load_start) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                end
            end
            LOAD: begin
                if (i_load_start) begin
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                end else if (i_load_valid) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (i_load_last || (wr_ptr_q == ADDR_W'(ROM_DEPTH_P - 1))) begin
                        state_d     = READY;
                        prog_len_d  = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            prog_len_q    <= '0;
            load_done_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            oob_q         <= 1'b0;
            instr_hold_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            prog_len_q    <= prog_len_d;
            load_done_q   <= load_done_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            oob_q         <= oob_d;
            instr_hold_q  <= instr_hold_d;
        end
    end
endmodule

// File: tb/tb_mest_pro_imem.sv
// tb/tb_mest_pro_imem.sv - randomized self-checking bench for mest_pro_imem
module tb_mest_pro_imem;
    import mest_pro_pkg::*;

    localparam int IW = INSTRUCTION_SIZE;
    localparam int AW = $clog2(ROM_DEPTH);

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_load_start;
    logic          i_load_valid;
    logic          i_load_last;
    logic [IW-1:0] i_load_data;
    logic          o_load_ready;
    logic          o_load_done;
    logic [AW:0]   o_prog_len;
    logic          o_prog_loaded;
    logic          i_req;
    logic [AW-1:0] i_prog_counter;
    logic [IW-1:0] o_instruction;
    logic          o_instr_valid;
    logic          o_fetch_err;

    always #5 clk = ~clk;

    mest_pro_imem dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_load_start   (i_load_start),
        .i_load_valid   (i_load_valid),
        .i_load_last    (i_load_last),
        .i_load_data    (i_load_data),
        .o_load_ready   (o_load_ready),
        .o_load_done    (o_load_done),
        .o_prog_len     (o_prog_len),
        .o_prog_loaded  (o_prog_loaded),
        .i_req          (i_req),
        .i_prog_counter (i_prog_counter),
        .o_instruction  (o_instruction),
        .o_instr_valid  (o_instr_valid),
        .o_fetch_err    (o_fetch_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: program image, loading/loaded flags, write count, length.
    logic [IW-1:0] mem_m [ROM_DEPTH];
    bit            m_loading;
    bit            m_loaded;
    int            m_wcount;
    int            m_len;
    logic [IW-1:0] m_instr;
    bit            e_done, e_valid, e_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit v, input bit l,
                        input logic [IW-1:0] d, input bit rq, input int pc);
        i_reset        = rst;
        i_load_start   = st;
        i_load_valid   = v;
        i_load_last    = l;
        i_load_data    = d;
        i_req          = rq;
        i_prog_counter = AW'(pc);
        e_done  = 0;
        e_valid = 0;
        e_err   = 0;
        if (rst) begin
            m_loading = 0;
            m_loaded  = 0;
            m_wcount  = 0;
            m_len     = 0;
            m_instr   = '0;
        end else begin
            if (rq) begin
                if (m_loaded) begin
                    e_valid = 1;
                    if (pc >= m_len) begin
                        m_instr = '0;
                        e_err   = 1;
                    end else begin
                        m_instr = mem_m[pc];
                    end
                end else begin
                    e_err = 1;
                end
            end
            if (st) begin
                m_loading = 1;
                m_loaded  = 0;
                m_wcount  = 0;
                m_len     = 0;
            end else if (m_loading && v) begin
                mem_m[m_wcount] = d;
                m_wcount++;
                if (l || m_wcount == ROM_DEPTH) begin
                    m_loading = 0;
                    m_loaded  = 1;
                    m_len     = m_wcount;
                    e_done    = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("load_ready",  32'(o_load_ready),  32'(m_loading));
        check_eq("load_done",   32'(o_load_done),   32'(e_done));
        check_eq("prog_len",    32'(o_prog_len),    32'(m_len));
        check_eq("prog_loaded", 32'(o_prog_loaded), 32'(m_loaded));
        check_eq("instr_valid", 32'(o_instr_valid), 32'(e_valid));
        check_eq("fetch_err",   32'(o_fetch_err),   32'(e_err));
        check_eq("instruction", 32'(o_instruction), 32'(m_instr));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0);
    endtask

    function automatic logic [IW-1:0] rnd_word();
        return IW'($urandom());
    endfunction

    initial begin
        i_reset = 1; i_load_start = 0; i_load_valid = 0; i_load_last = 0;
        i_load_data = '0; i_req = 0; i_prog_counter = '0;
        step(1, 0, 0, 0, '0, 0, 0);
        step(1, 0, 0, 0, '0, 0, 0);

        // Fetch with no program loaded is rejected.
        step(0, 0, 0, 0, '0, 1, 0);
        idle();

        // Four-word program, then back-to-back fetches and an out-of-range fetch.
        step(0, 1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, (i == 3), 28'hA00_0000 + IW'(i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 1, i);
        idle();
        step(0, 0, 0, 0, '0, 1, 7);
        idle();

        // Full image auto-completes; surplus words are ignored.
        step(0, 1, 0, 0, '0, 0, 0);
        for (int i = 0; i < ROM_DEPTH; i++) step(0, 0, 1, 0, rnd_word(), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, rnd_word(), 0, 0);
        step(0, 0, 0, 0, '0, 1, 255);
        step(0, 0, 0, 0, '0, 1, 0);

        // Restart with a same-cycle fetch, short reload, then reset mid-load.
        step(0, 1, 0, 0, '0, 1, 1);
        step(0, 0, 1, 0, rnd_word(), 1, 1);
        step(0, 1, 1, 0, rnd_word(), 0, 0);
        step(0, 0, 1, 0, rnd_word(), 0, 0);
        step(0, 0, 1, 1, rnd_word(), 0, 0);
        step(0, 0, 0, 0, '0, 1, 1);
        step(0, 0, 0, 0, '0, 1, 2);
        step(0, 1, 0, 0, '0, 0, 0);
        step(0, 0, 1, 0, rnd_word(), 1, 0);
        step(1, 0, 1, 0, rnd_word(), 1, 0);
        idle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit rst, st, v, l, rq;
            int pc;
            rst = ($urandom_range(0, 399) == 0);
            st  = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 2) != 0);
            l   = ($urandom_range(0, 19) == 0);
            rq  = ($urandom_range(0, 1) == 1);
            pc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROM_DEPTH - 1))
                                              : int'($urandom_range(0, m_len));
            if (pc > ROM_DEPTH - 1) pc = ROM_DEPTH - 1;
            step(rst, st, v, l, rnd_word(), rq, pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mest_pro_imem.md
Name: mest_pro_imem

Overview:
- Loadable program memory that sits directly upstream of the mest_pro core. It serves the core's instruction fetches (o_req / o_prog_counter → i_instruction on the core side).
- A simple valid/ready loader port lets a host or bench stream a program in at address 0 before the core is started.
- It tracks the loaded program length and flags any fetch outside the loaded image or made while no program is ready.

Parameters:
- OP_CODE_SIZE, 4, opcode field width
- INSTRUCTION_SIZE, OP_CODE_SIZE+8+8+8 (28), instruction word width
- ROM_DEPTH, 256, number of instruction words; ADDR_W = $clog2(ROM_DEPTH) (localparam)

Ports:
- clk  input  1  system clock, all logic on posedge
- i_reset  input  1  synchronous, active-high reset
- i_load_start  input  1  begin a new program load at address 0
- i_load_valid  input  1  i_load_data holds a word to write
- i_load_last  input  1  qualifies i_load_valid: final word of the program
- i_load_data  input  INSTRUCTION_SIZE  program word
- o_load_ready  output  1  block accepts load words (high only in LOAD)
- o_load_done  output  1  one-cycle pulse when a load completes
- o_prog_len  output  ADDR_W+1  number of words in the current image (0..ROM_DEPTH)
- o_prog_loaded  output  1  a complete image is present (state READY)
- i_req  input  1  fetch request from core
- i_prog_counter  input  ADDR_W  fetch address
- o_instruction  output  INSTRUCTION_SIZE  fetched word
- o_instr_valid  output  1  o_instruction is valid this cycle
- o_fetch_err  output  1  one-cycle pulse: rejected or out-of-range fetch

Behaviour:
- Reset values:
  - State is IDLE.
  - o_load_ready, o_load_done, o_prog_loaded, o_instr_valid and o_fetch_err are all 0.
  - o_instruction is 0 and o_prog_len is 0.
  - The write pointer is 0. Memory contents are not cleared.
- FSM IDLE → LOAD on i_load_start. READY → LOAD on i_load_start.
- LOAD:
  - o_load_ready = 1.
  - A word is written when i_load_valid && o_load_ready, at the write pointer; the pointer then increments.
  - If i_load_last is set, or the written address is ROM_DEPTH-1, the load completes:
    - next cycle the state is READY;
    - o_prog_len = pointer+1 (256 for a full image);
    - o_load_done pulses for 1 cycle;
    - o_prog_loaded = 1.
  - Extra words while not in LOAD are ignored (no write).
- i_load_start while in LOAD restarts the load:
  - the pointer returns to 0;
  - any write in that cycle is discarded;
  - o_prog_len is held at 0 until the load completes.
- Entering LOAD from READY clears o_prog_loaded and o_prog_len in the next cycle.
- Fetch latency is 1 cycle: i_req at edge N gives o_instr_valid = 1 and o_instruction = mem[i_prog_counter] at edge N+1. Fetches are fully pipelined, one per cycle.
- Error cases:
  - Fetch in READY with i_prog_counter ≥ o_prog_len: o_instr_valid = 1, o_instruction = NOP (all zeros), o_fetch_err pulses.
  - Fetch in IDLE or LOAD: o_instr_valid = 0, o_fetch_err pulses, o_instruction holds its previous value.
- If i_req and i_load_start arrive in the same READY cycle, the fetch is served from the old image (a read-before-write property) and the load begins.
- o_instruction holds its last value when there is no request.
- i_reset mid-load or mid-fetch:
  - everything returns to reset values next cycle;
  - any in-flight read result is dropped (o_instr_valid = 0).
- A write and a read to the same address in one cycle cannot occur, because reads are only served in READY and writes only occur in LOAD.

Decomposition:
- Package mest_pro_pkg holds:
  - OP_CODE_SIZE, INSTRUCTION_SIZE and ROM_DEPTH defaults;
  - the NOP instruction constant;
  - the imem_state_t enum {IDLE, LOAD, READY}.
- One sub-module, mest_pro_ram_1r1w: a synchronous 1-read/1-write RAM with registered read data (ROM_DEPTH × INSTRUCTION_SIZE).
- The FSM, pointer, length and range checks stay in mest_pro_imem.

Test Plan:
- Reset then fetch pc=0 → o_instr_valid=0 and a 1-cycle o_fetch_err; o_prog_loaded=0.
- Load 4 words A0..A3 with last on A3 → o_load_done pulse, o_prog_len=4; fetch pc=0..3 back-to-back → A0..A3 on 4 consecutive cycles, each 1 cycle after its request.
- With that 4-word image, fetch pc=7 → o_instr_valid=1, o_instruction=0, o_fetch_err=1.
- Load 256 words without i_load_last → auto-complete after word 255, o_prog_len=256; extra valid words are ignored; fetch pc=255 → word 255.
- Restart case: i_load_start in READY while i_req pc=1 in the same cycle → old word 1 returned; then load 2 words → o_prog_len=2. Assert i_reset mid-load → o_load_ready=0 and o_prog_len=0 next cycle.
